// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter sharing the page-table-walk AXI read port between ITLB and DTLB.
// Optional response timeout with stale-response discard is enabled by defining PTW_TIMEOUT_EN.
module ptw_mem_arbiter #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  I_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] I_REQ_ADDR,
    output logic                  I_RESP_VALID,
    output logic [DATA_WIDTH-1:0] I_RESP_DATA,
    output logic                  I_ACCESS_FAULT,
    input  logic                  D_REQ_VALID,
    input  logic [ADDR_WIDTH-1:0] D_REQ_ADDR,
    output logic                  D_RESP_VALID,
    output logic [DATA_WIDTH-1:0] D_RESP_DATA,
    output logic                  D_ACCESS_FAULT,
    output logic                  M_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0] M_ADDR,
    input  logic                  M_ADDR_READY,
    input  logic                  M_DATA_VALID,
    input  logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  BUSY,
    output logic                  OWNER
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [1:0]            r_state;
    logic                  r_m_addr_valid;
    logic [ADDR_WIDTH-1:0] r_m_addr;
    logic                  r_owner;
    logic                  r_last_grant;

    // Side index 0 is the ITLB, 1 is the DTLB.
    logic                  w_req_valid [2];
    logic [ADDR_WIDTH-1:0] w_req_addr  [2];
    logic [ADDR_WIDTH-1:0] w_eff_addr  [2];
    logic [1:0]            w_pend;
    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic [1:0]            w_resp_valid;
    logic [DATA_WIDTH-1:0] w_resp_data [2];
    logic [1:0]            w_fault;
    logic                  w_idle;
    logic                  w_block;
    logic                  w_timeout;
    logic                  w_data_hit;

    assign w_req_valid[0] = I_REQ_VALID;
    assign w_req_valid[1] = D_REQ_VALID;
    assign w_req_addr[0]  = I_REQ_ADDR;
    assign w_req_addr[1]  = D_REQ_ADDR;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_data_hit = (r_state == ST_WAIT) && M_DATA_VALID;

`ifdef PTW_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_stale;

    assign w_timeout = (r_state == ST_WAIT) && !M_DATA_VALID
                       && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_block   = r_stale;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt   <= '0;
            r_stale <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE && M_ADDR_READY) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT && !M_DATA_VALID) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // The abandoned walk's data may still arrive; swallow exactly one beat.
            if (w_timeout) begin
                r_stale <= 1'b1;
            end else if (M_DATA_VALID) begin
                r_stale <= 1'b0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_block   = 1'b0;
`endif

    // Tie goes to the side that was not granted last.
    assign w_grant[1] = w_idle && !w_block && w_req[1] && (!w_req[0] || !r_last_grant);
    assign w_grant[0] = w_idle && !w_block && w_req[0] && !w_grant[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_side
            logic                  r_pend;
            logic [ADDR_WIDTH-1:0] r_addr;
            logic                  r_resp_valid;
            logic [DATA_WIDTH-1:0] r_resp_data;
            logic                  w_mine;

            assign w_mine         = (r_owner == (gi != 0));
            assign w_pend[gi]     = r_pend;
            assign w_req[gi]      = r_pend | w_req_valid[gi];
            assign w_eff_addr[gi] = w_req_valid[gi] ? w_req_addr[gi] : r_addr;
            assign w_resp_valid[gi] = r_resp_valid;
            assign w_resp_data[gi]  = r_resp_data;
            assign w_fault[gi]      = w_timeout && w_mine;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_pend <= 1'b0;
                    r_addr <= '0;
                end else if (w_grant[gi]) begin
                    r_pend <= 1'b0;
                end else if (w_req_valid[gi]) begin
                    r_pend <= 1'b1;
                    r_addr <= w_req_addr[gi];
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_resp_valid <= 1'b0;
                    r_resp_data  <= '0;
                end else begin
                    r_resp_valid <= w_data_hit && w_mine;
                    if (w_data_hit && w_mine) begin
                        r_resp_data <= M_DATA;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state        <= ST_IDLE;
            r_m_addr_valid <= 1'b0;
            r_m_addr       <= '0;
            r_owner        <= 1'b0;
            r_last_grant   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant[0] || w_grant[1]) begin
                        r_m_addr       <= w_grant[1] ? w_eff_addr[1] : w_eff_addr[0];
                        r_m_addr_valid <= 1'b1;
                        r_owner        <= w_grant[1];
                        r_last_grant   <= w_grant[1];
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (M_ADDR_READY) begin
                        r_m_addr_valid <= 1'b0;
                        r_state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (M_DATA_VALID || w_timeout) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_m_addr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign I_RESP_VALID   = w_resp_valid[0];
    assign I_RESP_DATA    = w_resp_data[0];
    assign I_ACCESS_FAULT = w_fault[0];
    assign D_RESP_VALID   = w_resp_valid[1];
    assign D_RESP_DATA    = w_resp_data[1];
    assign D_ACCESS_FAULT = w_fault[1];
    assign M_ADDR_VALID   = r_m_addr_valid;
    assign M_ADDR         = r_m_addr;
    assign BUSY           = (r_state != ST_IDLE);
    assign OWNER          = r_owner;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed scoreboard bench for ptw_mem_arbiter: expected grants and responses are queued
// when stimulus is driven and compared when the arbiter produces them.
module tb_ptw_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        I_REQ_VALID = 1'b0;
    logic [63:0] I_REQ_ADDR = '0;
    logic        I_RESP_VALID;
    logic [63:0] I_RESP_DATA;
    logic        I_ACCESS_FAULT;
    logic        D_REQ_VALID = 1'b0;
    logic [63:0] D_REQ_ADDR = '0;
    logic        D_RESP_VALID;
    logic [63:0] D_RESP_DATA;
    logic        D_ACCESS_FAULT;
    logic        M_ADDR_VALID;
    logic [63:0] M_ADDR;
    logic        M_ADDR_READY = 1'b1;
    logic        M_DATA_VALID = 1'b0;
    logic [63:0] M_DATA = '0;
    logic        BUSY;
    logic        OWNER;

    ptw_mem_arbiter #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (64),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .I_REQ_VALID   (I_REQ_VALID),
        .I_REQ_ADDR    (I_REQ_ADDR),
        .I_RESP_VALID  (I_RESP_VALID),
        .I_RESP_DATA   (I_RESP_DATA),
        .I_ACCESS_FAULT(I_ACCESS_FAULT),
        .D_REQ_VALID   (D_REQ_VALID),
        .D_REQ_ADDR    (D_REQ_ADDR),
        .D_RESP_VALID  (D_RESP_VALID),
        .D_RESP_DATA   (D_RESP_DATA),
        .D_ACCESS_FAULT(D_ACCESS_FAULT),
        .M_ADDR_VALID  (M_ADDR_VALID),
        .M_ADDR        (M_ADDR),
        .M_ADDR_READY  (M_ADDR_READY),
        .M_DATA_VALID  (M_DATA_VALID),
        .M_DATA        (M_DATA),
        .BUSY          (BUSY),
        .OWNER         (OWNER)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        side;
        logic [63:0] val;
    } exp_t;

    exp_t q_addr[$];
    exp_t q_resp[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_owner = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        I_REQ_VALID = 1'b0;
        D_REQ_VALID = 1'b0;
        M_DATA_VALID = 1'b0;
        M_ADDR_READY = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_issue();
        exp_t e;
        chk("issue_expected", 64'(q_addr.size() != 0), 64'd1);
        if (q_addr.size() == 0) return;
        e = q_addr.pop_front();
        chk("m_addr_valid", M_ADDR_VALID, 1'b1);
        chk("m_addr", M_ADDR, e.val);
        chk("owner", OWNER, e.side);
        chk("busy_issue", BUSY, 1'b1);
        exp_owner = e.side;
        $display("issue  side=%0d addr=%h m_addr=%h", e.side, e.val, M_ADDR);
    endtask

    task automatic check_resp();
        exp_t e;
        chk("resp_expected", 64'(q_resp.size() != 0), 64'd1);
        if (q_resp.size() == 0) return;
        e = q_resp.pop_front();
        chk("i_resp_valid", I_RESP_VALID, (e.side == 1'b0));
        chk("d_resp_valid", D_RESP_VALID, (e.side == 1'b1));
        chk("resp_data", (e.side ? D_RESP_DATA : I_RESP_DATA), e.val);
        chk("busy_after_resp", BUSY, 1'b0);
        $display("resp   side=%0d data=%h", e.side, e.val);
    endtask

    task automatic respond(input logic [63:0] data);
        M_DATA_VALID = 1'b1;
        M_DATA = data;
        q_resp.push_back('{exp_owner, data});
        tick();
        M_DATA_VALID = 1'b0;
        check_resp();
    endtask

    // Called in the cycle M_ADDR_VALID is expected with M_ADDR_READY high.
    task automatic issue_and_complete(input logic [63:0] data);
        check_issue();
        tick();
        chk("m_addr_valid_drop", M_ADDR_VALID, 1'b0);
        chk("busy_wait", BUSY, 1'b1);
        respond(data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        RST = 1'b1;
        tick();
        chk("rst_m_addr_valid", M_ADDR_VALID, 1'b0);
        chk("rst_m_addr", M_ADDR, 64'd0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_owner", OWNER, 1'b0);
        chk("rst_i_resp", I_RESP_VALID, 1'b0);
        chk("rst_d_resp", D_RESP_VALID, 1'b0);
        chk("rst_faults", {I_ACCESS_FAULT, D_ACCESS_FAULT}, 2'b00);
        RST = 1'b0;

        // Single ITLB walk.
        I_REQ_VALID = 1'b1;
        I_REQ_ADDR = 64'h0000_0000_8000_1008;
        q_addr.push_back('{1'b0, 64'h0000_0000_8000_1008});
        tick();
        I_REQ_VALID = 1'b0;
        issue_and_complete(64'h0000_0000_2000_00CF);
        tick();
        chk("i_resp_one_cycle", I_RESP_VALID, 1'b0);
        chk("i_resp_data_hold", I_RESP_DATA, 64'h0000_0000_2000_00CF);
        chk("d_resp_quiet", D_RESP_VALID, 1'b0);

        // Tie out of reset: ITLB first, then DTLB, then ITLB wins the next tie.
        do_reset();
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h1000;
        D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h2000;
        q_addr.push_back('{1'b0, 64'h1000});
        q_addr.push_back('{1'b1, 64'h2000});
        tick();
        I_REQ_VALID = 1'b0; D_REQ_VALID = 1'b0;
        issue_and_complete(64'hAAAA_0001);
        chk("no_issue_at_r1", M_ADDR_VALID, 1'b0);
        tick();
        issue_and_complete(64'hBBBB_0002);
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h1100;
        D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h2200;
        q_addr.push_back('{1'b0, 64'h1100});
        q_addr.push_back('{1'b1, 64'h2200});
        tick();
        I_REQ_VALID = 1'b0; D_REQ_VALID = 1'b0;
        issue_and_complete(64'hAAAA_0003);
        tick();
        issue_and_complete(64'hBBBB_0004);

        // Address stalled by M_ADDR_READY low; a D request arrives meanwhile.
        M_ADDR_READY = 1'b0;
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h4440;
        q_addr.push_back('{1'b0, 64'h4440});
        tick();
        I_REQ_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", M_ADDR_VALID, 1'b1);
            chk("stall_addr", M_ADDR, 64'h4440);
            if (i == 2) begin
                D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h5550;
                q_addr.push_back('{1'b1, 64'h5550});
            end
            tick();
            D_REQ_VALID = 1'b0;
        end
        M_ADDR_READY = 1'b1;
        issue_and_complete(64'hCCCC_0005);
        tick();
        issue_and_complete(64'hDDDD_0006);

        // Spurious data in IDLE, then latest-wins pending address.
        tick();
        M_DATA_VALID = 1'b1; M_DATA = 64'hDEAD_BEEF;
        tick();
        M_DATA_VALID = 1'b0;
        chk("spurious_i_resp", I_RESP_VALID, 1'b0);
        chk("spurious_d_resp", D_RESP_VALID, 1'b0);
        chk("spurious_busy", BUSY, 1'b0);
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h3000;
        q_addr.push_back('{1'b0, 64'h3000});
        tick();
        I_REQ_VALID = 1'b0;
        check_issue();
        tick();
        D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h100;
        tick();
        D_REQ_ADDR = 64'h200;
        tick();
        D_REQ_VALID = 1'b0;
        q_addr.push_back('{1'b1, 64'h200});
        respond(64'hEEEE_0007);
        tick();
        issue_and_complete(64'hFFFF_0008);

        // Reset during WAIT, then a late response.
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h7000;
        q_addr.push_back('{1'b0, 64'h7000});
        tick();
        I_REQ_VALID = 1'b0;
        check_issue();
        tick();
        chk("pre_rst_wait", BUSY, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        M_DATA_VALID = 1'b1; M_DATA = 64'h1234_5678;
        tick();
        M_DATA_VALID = 1'b0;
        chk("late_i_resp", I_RESP_VALID, 1'b0);
        chk("late_d_resp", D_RESP_VALID, 1'b0);
        chk("late_i_data", I_RESP_DATA, 64'd0);
        chk("late_d_data", D_RESP_DATA, 64'd0);
        chk("late_busy", BUSY, 1'b0);
        chk("late_m_valid", M_ADDR_VALID, 1'b0);
        chk("late_m_addr", M_ADDR, 64'd0);
        chk("late_owner", OWNER, 1'b0);

`ifdef PTW_TIMEOUT_EN
        // DTLB walk times out; pending ITLB waits for the stale beat to be discarded.
        do_reset();
        D_REQ_VALID = 1'b1; D_REQ_ADDR = 64'h5000;
        q_addr.push_back('{1'b1, 64'h5000});
        tick();
        D_REQ_VALID = 1'b0;
        check_issue();
        tick();
        I_REQ_VALID = 1'b1; I_REQ_ADDR = 64'h6000;
        q_addr.push_back('{1'b0, 64'h6000});
        tick();
        I_REQ_VALID = 1'b0;
        for (int k = 2; k < 8; k++) begin
            chk("no_early_fault", D_ACCESS_FAULT, 1'b0);
            tick();
        end
        chk("d_fault", D_ACCESS_FAULT, 1'b1);
        chk("i_no_fault", I_ACCESS_FAULT, 1'b0);
        tick();
        chk("fault_one_cycle", D_ACCESS_FAULT, 1'b0);
        chk("timeout_idle", BUSY, 1'b0);
        tick();
        chk("stale_blocks", M_ADDR_VALID, 1'b0);
        M_DATA_VALID = 1'b1; M_DATA = 64'h5757;
        tick();
        M_DATA_VALID = 1'b0;
        chk("stale_d_resp", D_RESP_VALID, 1'b0);
        chk("stale_i_resp", I_RESP_VALID, 1'b0);
        chk("stale_no_issue", M_ADDR_VALID, 1'b0);
        tick();
        issue_and_complete(64'h6666_0009);
`endif

        chk("q_addr_empty", 64'(q_addr.size()), 64'd0);
        chk("q_resp_empty", 64'(q_resp.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
